// File: rtl/wb_stage.sv
// wb_stage -- write-back stage of the dual-issue pipeline.
//
// Latches one retiring bundle (inst1 plus an optional inst2) from the memory
// stage, drives both register-file write ports, the forwarding bus back to
// decode and the single-port commit trace.
//
// Compile-time option: WS_TRACE_SERIAL_EN
//   defined   : a two-instruction bundle retires over two cycles (inst1 then
//               inst2) so every instruction appears on the debug trace.
//   undefined : every bundle retires in one cycle, both write ports active
//               together, debug trace tied to 0.
//
// Ports:
//   clk                in   pipeline clock, rising edge
//   resetn             in   asynchronous active-low reset
//   ws_allowin         out  stage can accept a bundle this cycle
//   ms_to_ws_valid     in   memory stage presents a valid bundle
//   ms_to_ws_bus       in   141-bit bundle {inst2_valid, inst2 fields, inst1 fields}
//   ws_to_rf_bus       out  {we1, waddr1, wdata1, we2, waddr2, wdata2}
//   ws_forward_bus     out  {ws_valid, fwd1_we, dest1, result1, fwd2_we, dest2, result2}
//   debug_wb_pc        out  pc of the instruction committing this cycle
//   debug_wb_rf_wen    out  {4{gr_we}} of that commit
//   debug_wb_rf_wnum   out  destination register of that commit
//   debug_wb_rf_wdata  out  write data of that commit
module wb_stage (
  input  logic         clk,
  input  logic         resetn,
  output logic         ws_allowin,
  input  logic         ms_to_ws_valid,
  input  logic [140:0] ms_to_ws_bus,
  output logic [75:0]  ws_to_rf_bus,
  output logic [76:0]  ws_forward_bus,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_wen,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  logic         ws_valid;
  logic [140:0] bundle;
  logic         phase;

  logic         inst2_valid;
  logic         inst2_gr_we;
  logic [4:0]   inst2_dest;
  logic [31:0]  inst2_result;
  logic [31:0]  inst2_pc;
  logic         inst1_gr_we;
  logic [4:0]   inst1_dest;
  logic [31:0]  inst1_result;
  logic [31:0]  inst1_pc;

  logic         retire;
  logic         we1;
  logic         we2;
  logic         fwd1_we;
  logic         fwd2_we;

  assign {inst2_valid, inst2_gr_we, inst2_dest, inst2_result, inst2_pc,
          inst1_gr_we, inst1_dest, inst1_result, inst1_pc} = bundle;

`ifdef WS_TRACE_SERIAL_EN
  // A pair occupies two cycles; its second (phase 1) cycle is the retire cycle.
  assign retire = ws_valid && (phase || !inst2_valid);
`else
  assign retire = ws_valid;
`endif

  assign ws_allowin = !ws_valid || retire;

  // Bundle register: a new bundle is taken whenever the stage can accept one;
  // the previous bundle is held only while a serial pair is mid-retire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      bundle   <= '0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
      if (ms_to_ws_valid) begin
        bundle <= ms_to_ws_bus;
      end
    end
  end

  // Phase is 1 only in the cycle after a pair's inst1 slot. The stage refuses
  // input exactly when it must advance to the inst2 slot, so !ws_allowin is
  // the next phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase <= 1'b0;
    end else begin
`ifdef WS_TRACE_SERIAL_EN
      phase <= !ws_allowin;
`else
      phase <= 1'b0;
`endif
    end
  end

`ifdef WS_TRACE_SERIAL_EN
  // Each slot writes in its own cycle, so equal destinations resolve in
  // program order without suppression.
  assign we1     = ws_valid && inst1_gr_we && !phase;
  assign we2     = ws_valid && inst2_valid && inst2_gr_we && phase;
  assign fwd1_we = ws_valid && inst1_gr_we && !phase;
  assign fwd2_we = ws_valid && inst2_valid && inst2_gr_we;

  // Trace reports the slot retiring this cycle, zeros when idle.
  always_comb begin
    debug_wb_pc       = 32'h0;
    debug_wb_rf_wen   = 4'h0;
    debug_wb_rf_wnum  = 5'h0;
    debug_wb_rf_wdata = 32'h0;
    if (ws_valid) begin
      if (phase) begin
        debug_wb_pc       = inst2_pc;
        debug_wb_rf_wen   = {4{inst2_gr_we}};
        debug_wb_rf_wnum  = inst2_dest;
        debug_wb_rf_wdata = inst2_result;
      end else begin
        debug_wb_pc       = inst1_pc;
        debug_wb_rf_wen   = {4{inst1_gr_we}};
        debug_wb_rf_wnum  = inst1_dest;
        debug_wb_rf_wdata = inst1_result;
      end
    end
  end
`else
  logic same_dest;
  logic unused_trace;

  // Both ports write in the same cycle; when they target one register inst1
  // is dropped so the younger inst2 value lands.
  assign same_dest = inst1_gr_we && inst2_valid && inst2_gr_we &&
                     (inst1_dest == inst2_dest);
  assign we1       = ws_valid && inst1_gr_we && !same_dest;
  assign we2       = ws_valid && inst2_valid && inst2_gr_we;
  assign fwd1_we   = we1 && !phase;
  assign fwd2_we   = we2;

  assign debug_wb_pc       = 32'h0;
  assign debug_wb_rf_wen   = 4'h0;
  assign debug_wb_rf_wnum  = 5'h0;
  assign debug_wb_rf_wdata = 32'h0;

  // The pcs only feed the trace, which is tied off in this build.
  assign unused_trace = ^{inst1_pc, inst2_pc};
`endif

  assign ws_to_rf_bus   = {we1, inst1_dest, inst1_result,
                           we2, inst2_dest, inst2_result};
  assign ws_forward_bus = {ws_valid,
                           fwd1_we, inst1_dest, inst1_result,
                           fwd2_we, inst2_dest, inst2_result};

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- scoreboard bench for wb_stage.
// The driver offers bundles and, for each accepted one, queues the per-cycle
// outputs the stage must show; a monitor pops and compares them whenever the
// stage presents a valid bundle. Builds for either setting of WS_TRACE_SERIAL_EN.
module tb_wb_stage;

  logic         clk;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [140:0] ms_to_ws_bus;
  logic [75:0]  ws_to_rf_bus;
  logic [76:0]  ws_forward_bus;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_wen;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  typedef struct packed {
    logic        allowin;
    logic [75:0] rf;
    logic [76:0] fwd;
    logic [72:0] dbg;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .ws_forward_bus    (ws_forward_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [140:0] make_bundle(
    input logic i2v, input logic i2we, input logic [4:0] d2,
    input logic [31:0] r2, input logic [31:0] p2,
    input logic i1we, input logic [4:0] d1,
    input logic [31:0] r1, input logic [31:0] p1);
    return {i2v, i2we, d2, r2, p2, i1we, d1, r1, p1};
  endfunction

  function automatic logic [140:0] rand_bundle(input logic pair);
    logic [31:0] p1;
    p1 = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    return make_bundle(pair, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       $urandom, p1 + 32'd4,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       $urandom, p1);
  endfunction

  // Reference model: the cycle-by-cycle view of one retiring bundle, derived
  // instruction by instruction from the retire rules.
  task automatic push_expected(input logic [140:0] b);
    logic        i2v, i2we, i1we, same;
    logic [4:0]  d1, d2;
    logic [31:0] r1, r2, p1, p2;
    exp_t        e;
    i2v  = b[140];      i2we = b[139];      d2 = b[138:134];
    r2   = b[133:102];  p2   = b[101:70];
    i1we = b[69];       d1   = b[68:64];    r1 = b[63:32];   p1 = b[31:0];
`ifdef WS_TRACE_SERIAL_EN
    same      = 1'b0;
    e.allowin = !i2v;
    e.rf      = {i1we, d1, r1, 1'b0, d2, r2};
    e.fwd     = {1'b1, i1we, d1, r1, i2v && i2we, d2, r2};
    e.dbg     = {p1, {4{i1we}}, d1, r1};
    exp_q.push_back(e);
    if (i2v) begin
      e.allowin = 1'b1;
      e.rf      = {1'b0, d1, r1, i2we, d2, r2};
      e.fwd     = {1'b1, 1'b0, d1, r1, i2we, d2, r2};
      e.dbg     = {p2, {4{i2we}}, d2, r2};
      exp_q.push_back(e);
    end
`else
    same      = i1we && i2v && i2we && (d1 == d2);
    e.allowin = 1'b1;
    e.rf      = {i1we && !same, d1, r1, i2v && i2we, d2, r2};
    e.fwd     = {1'b1, i1we && !same, d1, r1, i2v && i2we, d2, r2};
    e.dbg     = '0;
    exp_q.push_back(e);
    if (p2 == 32'hFFFF_FFFF) e.dbg = '0;
`endif
  endtask

  // Offer one bundle from a falling edge; it is taken at the next rising edge
  // where the stage allows input. Waiting is bounded.
  task automatic applyStimulus(input logic valid, input logic [140:0] b);
    bit taken;
    @(negedge clk);
    ms_to_ws_valid = valid;
    ms_to_ws_bus   = b;
    if (valid) begin
      taken = 1'b0;
      for (int w = 0; w < 4 && !taken; w++) begin
        if (w > 0) @(negedge clk);
        if (ws_allowin) begin
          push_expected(b);
          taken = 1'b1;
        end
      end
      if (!taken) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL accept_timeout: got allowin=%b expected 1 within 4 cycles", ws_allowin);
      end
    end
  endtask

  // Monitor: checks the asynchronous reset view, then every cycle either pops
  // the expected valid-cycle view or checks the idle view.
  initial begin
    exp_t e;
    vectors     = 0;
    miscompares = 0;
    forever begin
      @(negedge clk or negedge resetn);
      if (!resetn) begin
        #1;
        checkOutput("reset_outputs",
                    256'({ws_allowin, ws_to_rf_bus, ws_forward_bus, debug_wb_pc,
                          debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
                    256'({1'b1, 76'b0, 77'b0, 73'b0}));
        exp_q.delete();
      end else if (ws_forward_bus[76]) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_commit: got ws_valid=1 expected 0");
        end else begin
          e = exp_q.pop_front();
          checkOutput("allowin", 256'(ws_allowin), 256'(e.allowin));
          checkOutput("rf_bus", 256'(ws_to_rf_bus), 256'(e.rf));
          checkOutput("forward_bus", 256'(ws_forward_bus), 256'(e.fwd));
          checkOutput("trace", 256'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
                                     debug_wb_rf_wdata}), 256'(e.dbg));
        end
      end else begin
        checkOutput("idle",
                    256'({ws_allowin, ws_to_rf_bus[75], ws_to_rf_bus[37],
                          ws_forward_bus[75], ws_forward_bus[37], debug_wb_pc,
                          debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
                    256'({1'b1, 4'b0, 73'b0}));
      end
    end
  end

  // Driver: directed scenarios, back-to-back singles, random traffic, a
  // mid-bundle reset, then a bounded drain.
  initial begin
    resetn         = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;

    // single instruction writing $5
    applyStimulus(1'b1, make_bundle(1'b0, 1'b0, 5'd0, 32'h0, 32'h0,
                                    1'b1, 5'd5, 32'h1234_5678, 32'hBFC0_0000));
    applyStimulus(1'b0, '0);
    // pair $3/$4 with the next bundle offered immediately behind it
    applyStimulus(1'b1, make_bundle(1'b1, 1'b1, 5'd4, 32'hB, 32'hBFC0_0008,
                                    1'b1, 5'd3, 32'hA, 32'hBFC0_0004));
    applyStimulus(1'b1, make_bundle(1'b0, 1'b0, 5'd0, 32'h0, 32'h0,
                                    1'b1, 5'd9, 32'hC, 32'hBFC0_000C));
    applyStimulus(1'b0, '0);
    // same-destination pair on $7
    applyStimulus(1'b1, make_bundle(1'b1, 1'b1, 5'd7, 32'h2, 32'hBFC0_0014,
                                    1'b1, 5'd7, 32'h1, 32'hBFC0_0010));
    // store/branch style instructions with no register write
    applyStimulus(1'b1, make_bundle(1'b0, 1'b0, 5'd0, 32'h0, 32'h0,
                                    1'b0, 5'd2, 32'hDEAD_BEEF, 32'hBFC0_0018));
    applyStimulus(1'b1, make_bundle(1'b1, 1'b0, 5'd6, 32'h55, 32'hBFC0_0020,
                                    1'b0, 5'd1, 32'h44, 32'hBFC0_001C));
    // write to $0 is passed through
    applyStimulus(1'b1, make_bundle(1'b0, 1'b0, 5'd0, 32'h0, 32'h0,
                                    1'b1, 5'd0, 32'h77, 32'hBFC0_0024));
    applyStimulus(1'b0, '0);

    // back-to-back single bundles
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, rand_bundle(1'b0));
    end
    applyStimulus(1'b0, '0);

    // random mixed traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) applyStimulus(1'b1, rand_bundle(1'($urandom_range(0, 1))));
      else applyStimulus(1'b0, '0);
    end

    // reset while a pair is in the stage
    applyStimulus(1'b1, make_bundle(1'b1, 1'b1, 5'd12, 32'h22, 32'hBFC0_1004,
                                    1'b1, 5'd11, 32'h11, 32'hBFC0_1000));
    @(posedge clk);
    #2;
    ms_to_ws_valid = 1'b0;
    resetn         = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b1;
    applyStimulus(1'b1, make_bundle(1'b1, 1'b1, 5'd14, 32'h44, 32'hBFC0_2004,
                                    1'b1, 5'd13, 32'h33, 32'hBFC0_2000));
    applyStimulus(1'b0, '0);

    // drain: every queued expectation must be consumed
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
